// File: rtl/tile_move_controller_pkg.sv
// Types shared by the tile move controller and the current-tile memory.
package tile_move_controller_pkg;

   typedef struct packed {
      logic signed [4:0] x;
      logic signed [5:0] y;
   } point_t;

   typedef enum logic [2:0] {
      eTileI, eTileO, eTileT, eTileS, eTileZ, eTileJ, eTileL
   } tile_type_e;

endpackage

// File: rtl/tile_move_controller.sv
// Turns button pulses and gravity into tile-memory position/rotation writes, locks and commits tiles.
// Moves strobe 2 cycles after a press; the next request waits for tm_ready_i; commit holds until accepted.
module tile_move_controller
   import tile_move_controller_pkg::*;
#(
   parameter int GRAVITY_TICKS = 1000,
   parameter int SPAWN_X       = 3,
   parameter int SPAWN_Y       = -2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [3:0] btn_i,
   input  logic       tm_ready_i,
   input  logic [3:0] tm_move_avail_i,
   input  point_t     tm_pos_i,
   input  tile_type_e tm_type_i,
   input  logic [1:0] tm_angle_i,
   input  tile_type_e tm_next_type_i,
   input  logic [1:0] tm_next_angle_i,
   input  logic       tm_in_game_area_i,
   output point_t     tm_new_pos_o,
   output logic       tm_pos_v_o,
   output tile_type_e tm_type_o,
   output logic [1:0] tm_angle_o,
   output logic       tm_type_v_o,
   output logic       tm_fetch_next_o,
   output logic       tm_empty_o,
   output logic       commit_v_o,
   input  logic       commit_ready_i,
   output logic       game_over_o
);

   localparam int GW = $clog2(GRAVITY_TICKS);
   localparam point_t SPAWN_PT = '{x: 5'(SPAWN_X), y: 6'(SPAWN_Y)};

   typedef enum logic [3:0] {
      eFetch, eLoad, eFetch2, eActive, eIssue, eWait, eCommit, eClear, eOver
   } state_t;

   state_t     state_q, state_d;
   state_t     ret_q, ret_d;
   logic       wait_first_q, wait_first_d;
   logic [3:0] pend_q, pend_d;
   logic [GW-1:0] grav_q, grav_d;

   point_t     new_pos_d;
   tile_type_e type_d;
   logic [1:0] angle_d;
   logic       pos_v_d, type_v_d, fetch_d, empty_d, commit_d, over_d;
   logic [3:0] clr;
   logic       grav_tick;

   always_comb begin
      state_d      = state_q;
      ret_d        = ret_q;
      wait_first_d = 1'b0;
      new_pos_d    = tm_new_pos_o;
      type_d       = tm_type_o;
      angle_d      = tm_angle_o;
      pos_v_d      = 1'b0;
      type_v_d     = 1'b0;
      fetch_d      = 1'b0;
      empty_d      = 1'b0;
      commit_d     = commit_v_o;
      over_d       = game_over_o;
      clr          = 4'b0000;
      grav_tick    = 1'b0;
      grav_d       = grav_q;

      if (state_q inside {eActive, eIssue, eWait}) begin
         if (grav_q == GW'(GRAVITY_TICKS - 1)) begin
            grav_d    = '0;
            grav_tick = 1'b1;
         end else begin
            grav_d = grav_q + GW'(1);
         end
      end

      case (state_q)
         eFetch: begin
            fetch_d      = 1'b1;
            ret_d        = eLoad;
            state_d      = eWait;
            wait_first_d = 1'b1;
         end
         eLoad: begin
            type_v_d     = 1'b1;
            pos_v_d      = 1'b1;
            type_d       = tm_next_type_i;
            angle_d      = tm_next_angle_i;
            new_pos_d    = SPAWN_PT;
            ret_d        = eFetch2;
            state_d      = eWait;
            wait_first_d = 1'b1;
         end
         eFetch2: begin
            fetch_d      = 1'b1;
            ret_d        = eActive;
            state_d      = eWait;
            wait_first_d = 1'b1;
         end
         eActive: begin
            // Priority rotate > left > right > down; only down can lock the tile.
            if (pend_q[3]) begin
               clr[3] = 1'b1;
               if (tm_move_avail_i[3]) begin
                  type_d   = tm_type_i;
                  angle_d  = tm_angle_i + 2'd1;
                  type_v_d = 1'b1;
                  state_d  = eIssue;
               end
            end else if (pend_q[0]) begin
               clr[0] = 1'b1;
               if (tm_move_avail_i[0]) begin
                  new_pos_d   = tm_pos_i;
                  new_pos_d.x = tm_pos_i.x - 5'd1;
                  pos_v_d     = 1'b1;
                  state_d     = eIssue;
               end
            end else if (pend_q[1]) begin
               clr[1] = 1'b1;
               if (tm_move_avail_i[1]) begin
                  new_pos_d   = tm_pos_i;
                  new_pos_d.x = tm_pos_i.x + 5'd1;
                  pos_v_d     = 1'b1;
                  state_d     = eIssue;
               end
            end else if (pend_q[2]) begin
               if (tm_move_avail_i[2]) begin
                  clr[2]      = 1'b1;
                  new_pos_d   = tm_pos_i;
                  new_pos_d.y = tm_pos_i.y + 6'd1;
                  pos_v_d     = 1'b1;
                  state_d     = eIssue;
               end else if (!tm_in_game_area_i) begin
                  over_d  = 1'b1;
                  state_d = eOver;
               end else begin
                  clr      = 4'b1111;
                  commit_d = 1'b1;
                  state_d  = eCommit;
               end
            end
         end
         eIssue: begin
            ret_d        = eActive;
            state_d      = eWait;
            wait_first_d = 1'b1;
         end
         eWait: begin
            // The memory only drops ready a cycle after our strobe, so skip the first look.
            if (!wait_first_q && tm_ready_i) state_d = ret_q;
         end
         eCommit: begin
            if (commit_v_o && commit_ready_i) begin
               commit_d = 1'b0;
               state_d  = eClear;
            end
         end
         eClear: begin
            empty_d = 1'b1;
            state_d = eLoad;
         end
         eOver: over_d = 1'b1;
         default: state_d = eFetch;
      endcase

      if (state_d == eLoad && state_q != eLoad) grav_d = '0;

      // Sets win over clears so a press landing on its own service is kept.
      pend_d = (pend_q & ~clr) | {1'b0, grav_tick, 2'b00};
      if (state_q != eOver) pend_d = pend_d | btn_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q         <= eFetch;
         ret_q           <= eFetch;
         wait_first_q    <= 1'b0;
         pend_q          <= 4'b0000;
         grav_q          <= '0;
         tm_new_pos_o    <= '0;
         tm_pos_v_o      <= 1'b0;
         tm_type_o       <= eTileI;
         tm_angle_o      <= 2'd0;
         tm_type_v_o     <= 1'b0;
         tm_fetch_next_o <= 1'b0;
         tm_empty_o      <= 1'b0;
         commit_v_o      <= 1'b0;
         game_over_o     <= 1'b0;
      end else begin
         state_q         <= state_d;
         ret_q           <= ret_d;
         wait_first_q    <= wait_first_d;
         pend_q          <= pend_d;
         grav_q          <= grav_d;
         tm_new_pos_o    <= new_pos_d;
         tm_pos_v_o      <= pos_v_d;
         tm_type_o       <= type_d;
         tm_angle_o      <= angle_d;
         tm_type_v_o     <= type_v_d;
         tm_fetch_next_o <= fetch_d;
         tm_empty_o      <= empty_d;
         commit_v_o      <= commit_d;
         game_over_o     <= over_d;
      end
   end

endmodule
